uart_rx_lb: RTL and testbench

//  UART receiver peripheral on the localbus; it is the receive-side counterpart of the existing txd transmitter.

---
 rtl/uart_rx_lb.sv | 260 ++++++++++++++++++++++++++
 tb/tb_uart_rx_lb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_lb.sv
// Localbus UART receiver: 2-flop rxd synchronizer, 8N1 deframer, byte FIFO and RXDATA/STATUS/DIV registers.
// Define UART_RX_PARITY_EN to receive 8E1 frames (adds a parity bit and STATUS[4] parity_err).
module uart_rx_lb #(
   parameter int DEFAULT_DIV = 868,
   parameter int FIFO_AW     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  addr,
   input  logic [31:0] qin,
   input  logic [3:0]  we,
   input  logic        re,
   output logic [31:0] qout,
   input  logic        rxd,
   output logic        int_uart_rx
);

   localparam int          DEPTH   = 2 ** FIFO_AW;
   localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIV);

   // state  | meaning
   // IDLE   | line idle, waiting for a synced 1->0 edge
   // START  | half-bit wait, then confirm start bit is still low
   // DATA   | eight data samples one bit-time apart, LSB first
   // PARITY | ninth sample, even parity check (parity build only)
   // STOP   | stop-bit sample; high pushes the byte, low flags frame error
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t      state;
   logic        rx_s1;
   logic        rx_s2;
   logic        rx_prev;
   logic        rx_fall;
   logic [15:0] div_reg;
   logic [15:0] div_half;
   logic [15:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        push_req;
   logic [7:0]  push_data;
   logic        frame_set;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               empty;
   logic               full;
   logic               pop;
   logic               push_ok;
   logic               overrun_set;

   logic        ie;
   logic        overrun;
   logic        frame_err;
   logic        par_bit;
   logic        wr;
   logic [1:0]  sel;
   logic        wr_status;
   logic [31:0] status_word;
   logic        unused_bits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rxd;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   assign rx_fall  = rx_prev & ~rx_s2;
   assign div_half = {1'b0, div_reg[15:1]};

`ifdef UART_RX_PARITY_EN
   logic parity_set;
   logic parity_err;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= 16'd0;
         bit_idx    <= 3'd0;
         shreg      <= 8'd0;
         push_req   <= 1'b0;
         push_data  <= 8'd0;
         frame_set  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_set <= 1'b0;
`endif
      end else begin
         push_req   <= 1'b0;
         frame_set  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_set <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (rx_fall) begin
                  state <= S_START;
                  cnt   <= div_half - 16'd1;
               end
            end
            S_START: begin
               if (cnt != 16'd0) begin
                  cnt <= cnt - 16'd1;
               end else if (rx_s2) begin
                  state <= S_IDLE;
               end else begin
                  state   <= S_DATA;
                  cnt     <= div_reg - 16'd1;
                  bit_idx <= 3'd0;
               end
            end
            S_DATA: begin
               if (cnt != 16'd0) begin
                  cnt <= cnt - 16'd1;
               end else begin
                  shreg   <= {rx_s2, shreg[7:1]};
                  cnt     <= div_reg - 16'd1;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt != 16'd0) begin
                  cnt <= cnt - 16'd1;
               end else begin
                  // even parity: data bits plus parity bit must XOR to zero
                  parity_set <= rx_s2 ^ (^shreg);
                  cnt        <= div_reg - 16'd1;
                  state      <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (cnt != 16'd0) begin
                  cnt <= cnt - 16'd1;
               end else begin
                  if (rx_s2) begin
                     push_req  <= 1'b1;
                     push_data <= shreg;
                  end else begin
                     frame_set <= 1'b1;
                  end
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign empty       = (count == '0);
   assign full        = (count == DEPTH[FIFO_AW:0]);
   assign wr          = |we;
   assign sel         = addr[3:2];
   assign wr_status   = wr && (sel == 2'd1);
   assign pop         = re && (sel == 2'd0) && !empty;
   // a same-cycle pop frees the slot, so a push on full is still accepted
   assign push_ok     = push_req && (!full || pop);
   assign overrun_set = push_req && full && !pop;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         end
         case ({push_ok, pop})
            2'b10:   count <= count + (FIFO_AW + 1)'(1);
            2'b01:   count <= count - (FIFO_AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= (parity_err & ~(wr_status & qin[4])) | parity_set;
      end
   end
   assign par_bit = parity_err;
`else
   assign par_bit = 1'b0;
`endif

   // sticky flags: hardware set takes priority over a same-cycle W1C
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie        <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         div_reg   <= DIV_RST;
      end else begin
         overrun   <= (overrun & ~(wr_status & qin[2])) | overrun_set;
         frame_err <= (frame_err & ~(wr_status & qin[3])) | frame_set;
         if (wr_status) begin
            ie <= qin[8];
         end
         if (wr && (sel == 2'd2)) begin
            div_reg <= (qin[15:0] < 16'd4) ? 16'd4 : qin[15:0];
         end
      end
   end

   assign status_word = {23'd0, ie, 3'd0, par_bit, frame_err, overrun, full, !empty};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qout        <= 32'd0;
         int_uart_rx <= 1'b0;
      end else begin
         int_uart_rx <= ie & !empty;
         if (re) begin
            case (sel)
               2'd0:    qout <= empty ? 32'd0 : {23'd0, 1'b1, mem[rd_ptr]};
               2'd1:    qout <= status_word;
               2'd2:    qout <= {16'd0, div_reg};
               default: qout <= 32'd0;
            endcase
         end
      end
   end

   assign unused_bits = ^{addr[1:0], qin[31:16]};

endmodule

// File: tb/tb_uart_rx_lb.sv
// Scoreboarded bench for uart_rx_lb: register reads queue expected words, a monitor checks qout.
module tb_uart_rx_lb;

   localparam int DIV = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  addr = 4'd0;
   logic [31:0] qin = 32'd0;
   logic [3:0]  we = 4'd0;
   logic        re = 1'b0;
   logic [31:0] qout;
   logic        rxd = 1'b1;
   logic        int_uart_rx;

   uart_rx_lb #(.DEFAULT_DIV(868), .FIFO_AW(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .addr        (addr),
      .qin         (qin),
      .we          (we),
      .re          (re),
      .qout        (qout),
      .rxd         (rxd),
      .int_uart_rx (int_uart_rx)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic        re_d = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   always @(posedge clk) re_d <= re;

   always @(negedge clk) begin
      if (re_d) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_read: got 0x%08h expected no read", qout);
         end else begin
            check(name_q.pop_front(), qout, exp_q.pop_front());
         end
      end
   end

   task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
      @(negedge clk);
      addr = a;
      re   = 1'b1;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(negedge clk);
      re = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a;
      qin  = d;
      we   = 4'hF;
      @(negedge clk);
      we = 4'h0;
   endtask

   task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_bit);
      rxd = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (DIV) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rxd = par_bit;
      repeat (DIV) @(negedge clk);
`endif
      rxd = stop_bit;
      repeat (DIV) @(negedge clk);
   endtask

   initial begin
      int waited;
      logic [7:0] b;
      repeat (3) @(negedge clk);
      check("qout_reset", qout, 32'd0);
      check("int_reset", {31'd0, int_uart_rx}, 32'd0);
      rst_n = 1'b1;
      rd(4'h4, 32'h0000_0000, "status_reset");
      rd(4'h8, 32'd868, "div_reset");
      rd(4'h0, 32'h0000_0000, "rxdata_empty");
      rd(4'hC, 32'h0000_0000, "reg_c");

      wr(4'h8, 32'd2);
      rd(4'h8, 32'd4, "div_clamp");
      wr(4'h8, DIV);
      rd(4'h9, DIV, "div_addr_lsb_ignored");
      wr(4'h4, 32'h100);
      rd(4'h4, 32'h100, "status_ie");

      // single byte, interrupt raise and clear
      send(8'hA5, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      check("int_after_a5", {31'd0, int_uart_rx}, 32'd1);
      rd(4'h0, 32'h0000_01A5, "rxdata_a5");
      repeat (2) @(negedge clk);
      check("int_after_pop", {31'd0, int_uart_rx}, 32'd0);
      rd(4'h4, 32'h100, "status_after_a5");

      // 17 bytes into a 16-deep FIFO
      for (int i = 0; i <= 16; i++) begin
         b = 8'(i);
         send(b, 1'b1, ^b);
      end
      repeat (20) @(negedge clk);
      rd(4'h4, 32'h107, "status_overrun_full");
      for (int i = 0; i < 16; i++) rd(4'h0, 32'h100 | i, "rxdata_fifo");
      rd(4'h4, 32'h104, "status_overrun_empty");
      wr(4'h4, 32'h104);
      rd(4'h4, 32'h100, "status_overrun_clr");

      // frame error on stop bit
      send(8'h3C, 1'b0, 1'b0);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      rd(4'h4, 32'h108, "status_frame_err");
      rd(4'h0, 32'h0, "rxdata_frame_err");
      wr(4'h4, 32'h108);
      rd(4'h4, 32'h100, "status_frame_clr");

      // short glitch on idle line
      @(negedge clk);
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      rd(4'h4, 32'h100, "status_glitch");
      rd(4'h0, 32'h0, "rxdata_glitch");

      // back-to-back frames with a pop landing on the second push
      fork
         begin
            send(8'h55, 1'b1, 1'b0);
            send(8'hAA, 1'b1, 1'b0);
         end
         begin
            waited = 0;
            while (int_uart_rx !== 1'b1 && waited < 400) begin
               @(negedge clk);
               waited++;
            end
            check("b2b_int_timeout", {31'd0, int_uart_rx}, 32'd1);
            repeat (157) @(negedge clk);
            rd(4'h0, 32'h155, "rxdata_b2b_first");
         end
      join
      repeat (10) @(negedge clk);
      rd(4'h0, 32'h1AA, "rxdata_b2b_second");
      rd(4'h4, 32'h100, "status_b2b");

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      rd(4'h4, 32'h111, "status_parity_err");
      rd(4'h0, 32'h107, "rxdata_parity_bad");
      wr(4'h4, 32'h110);
      rd(4'h4, 32'h100, "status_parity_clr");
      send(8'h07, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      rd(4'h4, 32'h101, "status_parity_ok");
      rd(4'h0, 32'h107, "rxdata_parity_ok");
`else
      wr(4'h4, 32'h110);
      rd(4'h4, 32'h100, "status_bit4_zero");
`endif

      waited = 0;
      while (exp_q.size() != 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
